// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate vector checker.
// Optional first-failure log is enabled by FIRST_FAIL_LOG_EN.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int GATE_NUM = 7;

    localparam int IDX_AND  = 0;
    localparam int IDX_OR   = 1;
    localparam int IDX_NOT  = 2;
    localparam int IDX_NAND = 3;
    localparam int IDX_NOR  = 4;
    localparam int IDX_XOR  = 5;
    localparam int IDX_XNOR = 6;

endpackage

// File: rtl/gate_vector_checker_golden.sv
// Golden truth table for the seven two-input gates.
module gate_golden_model
    import gate_chk_pkg::*;
(
    input  logic                a,
    input  logic                b,
    output logic [GATE_NUM-1:0] exp
);

    always_comb begin
        exp           = '0;
        exp[IDX_AND]  = a & b;
        exp[IDX_OR]   = a | b;
        exp[IDX_NOT]  = ~a;
        exp[IDX_NAND] = ~(a & b);
        exp[IDX_NOR]  = ~(a | b);
        exp[IDX_XOR]  = a ^ b;
        exp[IDX_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps a,b over all four combinations and checks the gate unit outputs.
// Define FIRST_FAIL_LOG_EN to add the fail_vec/fail_mask first-failure log.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             and_y,
    input  logic             or_y,
    input  logic             not_y,
    input  logic             nand_y,
    input  logic             nor_y,
    input  logic             xor_y,
    input  logic             xnor_y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef FIRST_FAIL_LOG_EN
    output logic [1:0]       fail_vec,
    output logic [6:0]       fail_mask,
`endif
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state, state_nx;

    logic [1:0]          idx;
    logic [7:0]          pidx;
    logic [3:0]          scnt;
    logic [GATE_NUM-1:0] exp_v;
    logic [GATE_NUM-1:0] got;
    logic [GATE_NUM-1:0] diff;
    logic                mismatch;
    logic                last_vec;
    logic                start_ok;

    gate_golden_model u_golden (
        .a  (a),
        .b  (b),
        .exp(exp_v)
    );

    always_comb begin
        got           = '0;
        got[IDX_AND]  = and_y;
        got[IDX_OR]   = or_y;
        got[IDX_NOT]  = not_y;
        got[IDX_NAND] = nand_y;
        got[IDX_NOR]  = nor_y;
        got[IDX_XOR]  = xor_y;
        got[IDX_XNOR] = xnor_y;
    end

    // Case inequality so X/Z on a gate output counts as a mismatch.
    always_comb begin
        diff = '0;
        for (int i = 0; i < GATE_NUM; i++) begin
            diff[i] = (got[i] !== exp_v[i]);
        end
    end

    assign mismatch = |diff;
    assign last_vec = (idx == 2'b11) && (pidx == 8'(NUM_PASSES - 1));
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    assign busy = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) state_nx = DRIVE;
            end
            DRIVE: begin
                state_nx = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
            end
            SETTLE: begin
                if (scnt == 4'd0) state_nx = CHECK;
            end
            CHECK: begin
                state_nx = last_vec ? DONE : DRIVE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= 2'b00;
            pidx    <= 8'd0;
            scnt    <= 4'd0;
            a       <= 1'b0;
            b       <= 1'b0;
            vec_cnt <= '0;
            err_cnt <= '0;
        end else if (start_ok) begin
            idx     <= 2'b00;
            pidx    <= 8'd0;
            a       <= 1'b0;
            b       <= 1'b0;
            vec_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (state == DRIVE) begin
                scnt <= 4'(SETTLE_CYCLES - 1);
            end
            if ((state == SETTLE) && (scnt != 4'd0)) begin
                scnt <= scnt - 4'd1;
            end
            if (state == CHECK) begin
                if (vec_cnt != CNT_MAX) vec_cnt <= vec_cnt + 1'b1;
                if (mismatch && (err_cnt != CNT_MAX)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                idx <= idx + 2'd1;
                if (idx == 2'b11) pidx <= pidx + 8'd1;
                // Hold the final vector on a,b while sitting in DONE.
                if (!last_vec) begin
                    a <= idx[0] ? ~idx[1] : idx[1];
                    b <= ~idx[0];
                end
            end
        end
    end

`ifdef FIRST_FAIL_LOG_EN
    logic fail_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_seen <= 1'b0;
            fail_vec  <= 2'b00;
            fail_mask <= 7'd0;
        end else if (start_ok) begin
            fail_seen <= 1'b0;
            fail_vec  <= 2'b00;
            fail_mask <= 7'd0;
        end else if ((state == CHECK) && mismatch && !fail_seen) begin
            fail_seen <= 1'b1;
            fail_vec  <= {a, b};
            fail_mask <= diff;
        end
    end
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: three checker configurations driving a faultable gate unit.
module tb_gate_vector_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_v = 3'b000;
    logic [2:0] a_v, b_v, busy_v, done_v, pass_v;
    logic [7:0] vec_v [3];
    logic [7:0] err_v [3];
    logic [1:0] vec2, err2;
    logic [6:0] g_v [3];
    int         mode_v [3] = '{0, 0, 0};
    int         period_v [3] = '{3, 5, 3};
`ifdef FIRST_FAIL_LOG_EN
    logic [1:0] fvec_v [3];
    logic [6:0] fmask_v [3];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate unit with selectable faults: 1 xor sa0, 2 all inverted,
    // 3 nand sa1, 4 or sa0.
    function automatic logic [6:0] gates(input logic a, input logic b,
                                         input int m);
        logic [6:0] g;
        g[0] = a & b;
        g[1] = a | b;
        g[2] = ~a;
        g[3] = ~(a & b);
        g[4] = ~(a | b);
        g[5] = a ^ b;
        g[6] = ~(a ^ b);
        case (m)
            1: g[5] = 1'b0;
            2: g = ~g;
            3: g[3] = 1'b1;
            4: g[1] = 1'b0;
            default: ;
        endcase
        return g;
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_gate
        assign g_v[i] = gates(a_v[i], b_v[i], mode_v[i]);
    end

    gate_vector_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .and_y(g_v[0][0]), .or_y(g_v[0][1]), .not_y(g_v[0][2]),
        .nand_y(g_v[0][3]), .nor_y(g_v[0][4]), .xor_y(g_v[0][5]),
        .xnor_y(g_v[0][6]),
        .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]),
`ifdef FIRST_FAIL_LOG_EN
        .fail_vec(fvec_v[0]), .fail_mask(fmask_v[0]),
`endif
        .vec_cnt(vec_v[0]), .err_cnt(err_v[0])
    );

    gate_vector_checker #(.SETTLE_CYCLES(3), .NUM_PASSES(2), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .and_y(g_v[1][0]), .or_y(g_v[1][1]), .not_y(g_v[1][2]),
        .nand_y(g_v[1][3]), .nor_y(g_v[1][4]), .xor_y(g_v[1][5]),
        .xnor_y(g_v[1][6]),
        .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]),
`ifdef FIRST_FAIL_LOG_EN
        .fail_vec(fvec_v[1]), .fail_mask(fmask_v[1]),
`endif
        .vec_cnt(vec_v[1]), .err_cnt(err_v[1])
    );

    gate_vector_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .and_y(g_v[2][0]), .or_y(g_v[2][1]), .not_y(g_v[2][2]),
        .nand_y(g_v[2][3]), .nor_y(g_v[2][4]), .xor_y(g_v[2][5]),
        .xnor_y(g_v[2][6]),
        .a(a_v[2]), .b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]),
`ifdef FIRST_FAIL_LOG_EN
        .fail_vec(fvec_v[2]), .fail_mask(fmask_v[2]),
`endif
        .vec_cnt(vec2), .err_cnt(err2)
    );

    assign vec_v[2] = {6'd0, vec2};
    assign err_v[2] = {6'd0, err2};

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Starts a run on checker s and counts cycles until done; bad counts
    // a,b/busy sequence errors. extra_at pulses start again mid-run.
    task automatic run(input int s, input int extra_at,
                       output int cyc, output int bad);
        int per;
        per = period_v[s];
        start_v[s] = 1'b1;
        @(posedge clk); #1;
        start_v[s] = 1'b0;
        cyc = 0;
        bad = 0;
        if (vec_v[s] != 8'd0 || done_v[s]) bad++;
        while (!done_v[s] && cyc < 200) begin
            if ({a_v[s], b_v[s]} != 2'((cyc / per) % 4)) bad++;
            if (!busy_v[s]) bad++;
            if (cyc == extra_at) start_v[s] = 1'b1;
            @(posedge clk); #1;
            start_v[s] = 1'b0;
            cyc++;
        end
    endtask

    typedef struct {
        int         sel;
        int         mode;
        int         cyc;
        int         vec;
        int         err;
        logic       pas;
        logic [1:0] fv;
        logic [6:0] fm;
    } row_t;

    row_t tbl [8];

    initial begin
        int cyc, bad;
        tbl[0] = '{0, 0, 12, 4, 0, 1'b1, 2'd0, 7'h00};
        tbl[1] = '{0, 1, 12, 4, 2, 1'b0, 2'd1, 7'h20};
        tbl[2] = '{0, 3, 12, 4, 1, 1'b0, 2'd3, 7'h08};
        tbl[3] = '{0, 4, 12, 4, 3, 1'b0, 2'd1, 7'h02};
        tbl[4] = '{1, 0, 40, 8, 0, 1'b1, 2'd0, 7'h00};
        tbl[5] = '{1, 2, 40, 8, 8, 1'b0, 2'd0, 7'h7f};
        tbl[6] = '{2, 2, 24, 3, 3, 1'b0, 2'd0, 7'h7f};
        tbl[7] = '{2, 0, 24, 3, 0, 1'b1, 2'd0, 7'h00};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ab", {a_v[0], b_v[0]}, 0);
        chk("rst_busy", busy_v[0], 0);
        chk("rst_done", done_v[0], 0);
        chk("rst_pass", pass_v[0], 0);
        chk("rst_vec", vec_v[0], 0);
        chk("rst_err", err_v[0], 0);

        for (int i = 0; i < 8; i++) begin
            mode_v[tbl[i].sel] = tbl[i].mode;
            run(tbl[i].sel, -1, cyc, bad);
            chk($sformatf("row%0d_cycles", i), cyc, tbl[i].cyc);
            chk($sformatf("row%0d_seq", i), bad, 0);
            chk($sformatf("row%0d_vec", i), vec_v[tbl[i].sel], tbl[i].vec);
            chk($sformatf("row%0d_err", i), err_v[tbl[i].sel], tbl[i].err);
            chk($sformatf("row%0d_pass", i), pass_v[tbl[i].sel],
                tbl[i].pas);
`ifdef FIRST_FAIL_LOG_EN
            chk($sformatf("row%0d_fvec", i), fvec_v[tbl[i].sel], tbl[i].fv);
            chk($sformatf("row%0d_fmask", i), fmask_v[tbl[i].sel],
                tbl[i].fm);
`endif
        end

        mode_v[0] = 0;
        run(0, 5, cyc, bad);
        chk("ign_cycles", cyc, 12);
        chk("ign_seq", bad, 0);
        chk("ign_vec", vec_v[0], 4);
        chk("ign_err", err_v[0], 0);

        mode_v[0] = 1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_ab", {a_v[0], b_v[0]}, 2);
        chk("mid_vec", vec_v[0], 2);
        rst = 1'b1;
        #1;
        chk("mrst_ab", {a_v[0], b_v[0]}, 0);
        chk("mrst_vec", vec_v[0], 0);
        chk("mrst_err", err_v[0], 0);
        chk("mrst_busy", busy_v[0], 0);
        @(posedge clk); #1;
        chk("mrst_done", done_v[0], 0);
        chk("mrst_vec2", vec_v[0], 0);
        rst = 1'b0;
        mode_v[0] = 0;
        run(0, -1, cyc, bad);
        chk("fresh_cycles", cyc, 12);
        chk("fresh_seq", bad, 0);
        chk("fresh_vec", vec_v[0], 4);
        chk("fresh_pass", pass_v[0], 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
